// File: rtl/gpio_param_pkg.sv
// gpio_param_pkg: opcodes, FSM state codes and GPIO field positions shared by the parameter writer and readback mux
package gpio_param_pkg;
    typedef enum logic [1:0] {
        OP_ADDR   = 2'b00,
        OP_LO     = 2'b01,
        OP_HI     = 2'b10,
        OP_COMMIT = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GOT_ADDR = 2'd1,
        S_GOT_LO   = 2'd2,
        S_GOT_HI   = 2'd3
    } state_e;
    // Field positions are counted down from the word MSB so they hold for any GPIO width.
    localparam int TGL_OFS  = 1;
    localparam int OP_OFS   = 2;
    localparam int OP_W     = 2;
    localparam int SETF_OFS = 5;
    localparam int SETF_W   = 4;
    localparam int IDX_W    = 4;
endpackage

// File: rtl/gpio_in_sync.sv
// gpio_in_sync: GPIO input stage, 2-FF synchronizer with GPIO_PARAM_SYNC_EN, single register otherwise
// Ports: clk, rst (async, active-high), d (raw GPIO word), q (sampled word, all bits captured together)
module gpio_in_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
`ifdef GPIO_PARAM_SYNC_EN
    logic [WIDTH-1:0] meta_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end
`endif
endmodule

// File: rtl/gpio_param_writer.sv
// gpio_param_writer: decodes toggle-strobed GPIO commands into 32-bit writes of a registered parameter bank
// Ports: CLK, RST (async, active-high), GP_IN (command word), SET (owned set ID), GP_OUT (ACK/ERR/state/IDX),
//        PARAMS_DATA (flattened bank), PARAM_UPD (one-cycle commit pulse per index).
// Config: define GPIO_PARAM_SYNC_EN for a 2-FF input synchronizer (3-cycle latency instead of 2).
module gpio_param_writer
    import gpio_param_pkg::*;
#(
    parameter int GPIO_WIDTH  = 32,
    parameter int PARAM_COUNT = 16,
    parameter logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAM_DEFAULTS = '0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [GPIO_WIDTH-1:0]             GP_IN,
    input  logic [3:0]                        SET,
    output logic [GPIO_WIDTH-1:0]             GP_OUT,
    output logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAMS_DATA,
    output logic [PARAM_COUNT-1:0]            PARAM_UPD
);
    localparam int W = GPIO_WIDTH;
    localparam int H = GPIO_WIDTH / 2;
    logic [W-1:0] in_s;
    gpio_in_sync #(.WIDTH(W)) u_sync (.clk(CLK), .rst(RST), .d(GP_IN), .q(in_s));
    state_e                   state_q, state_d;
    logic                     tgl_q, tgl_d;
    logic [SETF_W-1:0]        set_q, set_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [H-1:0]             lo_q, lo_d, hi_q, hi_d;
    logic                     err_q, err_d, ack_q, ack_d;
    logic [PARAM_COUNT-1:0]   upd_q, upd_d;
    logic [PARAM_COUNT*W-1:0] params_q, params_d;
    logic                     cmd, wr, set_ok, in_range;
    op_e                      op;
    logic [SETF_W-1:0]        setf;
    logic                     unused_bits;
    assign unused_bits = ^{in_s[W-4], in_s[W-9:H]};
    always_comb begin
        tgl_d    = in_s[W-TGL_OFS];
        cmd      = tgl_d != tgl_q;
        op       = op_e'(in_s[W-OP_OFS -: OP_W]);
        setf     = in_s[W-SETF_OFS -: SETF_W];
        set_ok   = set_q == SET;
        in_range = int'(idx_q) < PARAM_COUNT;
        state_d  = state_q;
        set_d    = set_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        err_d    = err_q;
        ack_d    = ack_q ^ cmd;
        wr       = 1'b0;
        if (cmd) begin
            if (op == OP_ADDR) begin
                // ADDR always restarts the sequence; only a matching set may clear a sticky error.
                state_d = S_GOT_ADDR;
                set_d   = setf;
                idx_d   = in_s[IDX_W-1:0];
                lo_d    = '0;
                hi_d    = '0;
                err_d   = (setf == SET) ? 1'b0 : err_q;
            end else if (op == OP_LO && state_q == S_GOT_ADDR) begin
                state_d = S_GOT_LO;
                lo_d    = in_s[H-1:0];
            end else if (op == OP_HI && state_q == S_GOT_LO) begin
                state_d = S_GOT_HI;
                hi_d    = in_s[H-1:0];
            end else if (op == OP_COMMIT && state_q == S_GOT_HI) begin
                // A foreign set is silently ignored so several writers can share one channel.
                state_d = S_IDLE;
                wr      = set_ok && in_range;
                err_d   = (set_ok && !in_range) ? 1'b1 : err_q;
            end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end
        end
        params_d = params_q;
        upd_d    = '0;
        for (int i = 0; i < PARAM_COUNT; i++) begin
            if (wr && idx_q == IDX_W'(i)) begin
                params_d[i*W +: W] = {hi_q, lo_q};
                upd_d[i]           = 1'b1;
            end
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            tgl_q    <= 1'b0;
            set_q    <= '0;
            idx_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
            upd_q    <= '0;
            params_q <= PARAM_DEFAULTS;
        end else begin
            state_q  <= state_d;
            tgl_q    <= tgl_d;
            set_q    <= set_d;
            idx_q    <= idx_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            upd_q    <= upd_d;
            params_q <= params_d;
        end
    end
    assign GP_OUT      = {ack_q, err_q, state_q, {(W-4-IDX_W){1'b0}}, idx_q};
    assign PARAMS_DATA = params_q;
    assign PARAM_UPD   = upd_q;
endmodule

// File: tb/tb_gpio_param_writer.sv
// tb_gpio_param_writer: directed and randomized command sequences checked against a behavioural bank model
module tb_gpio_param_writer;
    localparam int W  = 32;
    localparam int PC = 8;
    localparam logic [3:0] MY_SET = 4'h5;
    localparam logic [PC*W-1:0] DEF = {32'h0707_0707, 32'h0606_0606, 32'h0505_0505, 32'h0404_0404,
                                       32'h0303_0303, 32'h0202_0202, 32'h0101_0101, 32'hDEAD_BEEF};
`ifdef GPIO_PARAM_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    gp_in = '0;
    logic [3:0]      set_id = MY_SET;
    logic [W-1:0]    gp_out;
    logic [PC*W-1:0] params;
    logic [PC-1:0]   upd;

    gpio_param_writer #(.GPIO_WIDTH(W), .PARAM_COUNT(PC), .PARAM_DEFAULTS(DEF)) dut (
        .CLK(clk), .RST(rst), .GP_IN(gp_in), .SET(set_id),
        .GP_OUT(gp_out), .PARAMS_DATA(params), .PARAM_UPD(upd)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int errs = 0;
    logic [PC*W-1:0] def_v;
    // Behavioural view of the writer: what the host has told it so far.
    logic [31:0] m_bank [PC];
    logic        m_ack, m_err;
    int          m_step;
    logic [3:0]  m_set, m_idx;
    logic [15:0] m_lo, m_hi;
    logic [PC-1:0] exp_upd;
    logic        tgl = 1'b0;
    logic [PC-1:0] upd_seen;
    int          upd_cycles = 0;
    int          ack_tgls = 0;
    logic        ack_prev = 1'b0;

    always @(negedge clk) begin
        if (upd != '0) begin
            upd_seen   = upd_seen | upd;
            upd_cycles = upd_cycles + 1;
        end
        if (gp_out[W-1] !== ack_prev) begin
            ack_tgls = ack_tgls + 1;
            ack_prev = gp_out[W-1];
        end
    end

    task automatic check(input string tag, input logic [PC*W-1:0] obs, input logic [PC*W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PC*W-1:0] m_flat();
        logic [PC*W-1:0] f;
        for (int i = 0; i < PC; i++) f[i*W +: W] = m_bank[i];
        return f;
    endfunction

    function automatic logic [W-1:0] m_gp_out();
        logic [1:0] s;
        s = 2'(m_step);
        return {m_ack, m_err, s, 24'h0, m_idx};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PC; i++) m_bank[i] = def_v[i*W +: W];
        m_ack = 0; m_err = 0; m_step = 0; m_set = 0; m_idx = 0; m_lo = 0; m_hi = 0;
    endtask

    // Spec rules: ADDR restarts, LO/HI/COMMIT must follow in order, COMMIT writes only on own set and valid index.
    task automatic model_cmd(input logic [1:0] op, input logic [3:0] sf, input logic [15:0] half);
        m_ack = ~m_ack;
        exp_upd = '0;
        if (op == 2'b00) begin
            m_step = 1; m_set = sf; m_idx = half[3:0]; m_lo = 0; m_hi = 0;
            if (sf == MY_SET) m_err = 0;
        end else if (op == 2'b01 && m_step == 1) begin
            m_step = 2; m_lo = half;
        end else if (op == 2'b10 && m_step == 2) begin
            m_step = 3; m_hi = half;
        end else if (op == 2'b11 && m_step == 3) begin
            m_step = 0;
            if (m_set == MY_SET) begin
                if (m_idx < PC) begin
                    m_bank[m_idx] = {m_hi, m_lo};
                    exp_upd = PC'(1) << m_idx;
                end else m_err = 1;
            end
        end else begin
            m_step = 0; m_err = 1;
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] sf, input logic [15:0] half);
        int n;
        model_cmd(op, sf, half);
        upd_seen   = '0;
        upd_cycles = 0;
        tgl   = ~tgl;
        gp_in = {tgl, op, 1'b0, sf, 8'h00, half};
        n = 0;
        while (gp_out[W-1] !== tgl && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(LAT));
        repeat (2) @(negedge clk);
        #1;
        check("gp_out", gp_out, m_gp_out());
        check("bank", params, m_flat());
        check("upd_mask", upd_seen, exp_upd);
        check("upd_cycles", 32'(upd_cycles), (exp_upd != '0) ? 1 : 0);
    endtask

    task automatic seq(input logic [3:0] sf, input logic [3:0] idx, input logic [31:0] val);
        cmd(2'b00, sf, {12'h0, idx});
        cmd(2'b01, sf, val[15:0]);
        cmd(2'b10, sf, val[31:16]);
        cmd(2'b11, sf, 16'h0);
    endtask

    initial begin
        logic [W-1:0]    held_out;
        logic [PC*W-1:0] held_bank;
        def_v = DEF;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_gp_out", gp_out, '0);
        check("reset_bank", params, def_v);
        check("reset_upd", upd, '0);
        rst = 0;
        repeat (2) @(negedge clk);
        // 1: matching set write
        ack_tgls = 0;
        seq(MY_SET, 4'd3, 32'h1234_5678);
        check("t1_bank3", params[3*W +: W], 32'h1234_5678);
        check("t1_acks", 32'(ack_tgls), 32'd4);
        check("t1_err", gp_out[W-2], 1'b0);
        // 2: foreign set is silently ignored
        ack_tgls = 0;
        seq(4'hA, 4'd2, 32'hCAFE_F00D);
        check("t2_bank2", params[2*W +: W], def_v[2*W +: W]);
        check("t2_acks", 32'(ack_tgls), 32'd4);
        check("t2_err", gp_out[W-2], 1'b0);
        // 3: out-of-range index, then recovery by ADDR
        seq(MY_SET, 4'd15, 32'h0BAD_0BAD);
        check("t3_err", gp_out[W-2], 1'b1);
        cmd(2'b00, MY_SET, 16'h0001);
        check("t3_err_clr", gp_out[W-2], 1'b0);
        // 4: out-of-order, then an ADDR restart
        cmd(2'b00, MY_SET, 16'h0001);
        cmd(2'b10, MY_SET, 16'h7777);
        check("t4_err", gp_out[W-2:W-4], 3'b100);
        cmd(2'b00, MY_SET, 16'h0004);
        cmd(2'b01, MY_SET, 16'hAAAA);
        seq(MY_SET, 4'd6, 32'h2222_1111);
        check("t4_bank6", params[6*W +: W], 32'h2222_1111);
        check("t4_bank4", params[4*W +: W], def_v[4*W +: W]);
        // 5: reset between HI and COMMIT
        cmd(2'b00, MY_SET, 16'h0002);
        cmd(2'b01, MY_SET, 16'h3333);
        cmd(2'b10, MY_SET, 16'h4444);
        tgl = 0;
        gp_in = '0;
        rst = 1;
        @(negedge clk);
        #1;
        check("t5_gp_out", gp_out, '0);
        check("t5_bank", params, def_v);
        model_reset();
        rst = 0;
        ack_prev = 0;
        repeat (2) @(negedge clk);
        cmd(2'b11, MY_SET, 16'h0);
        check("t5_commit_err", gp_out[W-2], 1'b1);
        // 6: static TGL with noise on every other bit must do nothing
        held_out  = gp_out;
        held_bank = params;
        ack_tgls  = 0;
        for (int i = 0; i < 100; i++) begin
            gp_in = {tgl, 31'($urandom)};
            @(negedge clk);
        end
        repeat (LAT + 1) @(negedge clk);
        #1;
        check("t6_acks", 32'(ack_tgls), 32'd0);
        check("t6_gp_out", gp_out, held_out);
        check("t6_bank", params, held_bank);
        // random traffic
        for (int k = 0; k < 40; k++) begin
            logic [3:0] sf;
            sf = ($urandom_range(0, 3) != 0) ? MY_SET : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 6)
                seq(sf, 4'($urandom_range(0, 15)), $urandom);
            else
                cmd(2'($urandom_range(0, 3)), sf, 16'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
